// File: rtl/lsq_address_pipe_pkg.sv
// Shared widths, memory-op type codes and decode helpers for the LSQ address pipe.
// Load codes LB..LHU and store codes SB..SW are kept contiguous so range checks decode them.
package lsq_address_pipe_pkg;

  localparam int unsigned XLEN_W      = 32;
  localparam int unsigned ROB_TAG_W   = 4;
  localparam int unsigned TYPE_CODE_W = 6;

  localparam int unsigned LB  = 1;
  localparam int unsigned LH  = 2;
  localparam int unsigned LW  = 3;
  localparam int unsigned LBU = 4;
  localparam int unsigned LHU = 5;
  localparam int unsigned SB  = 6;
  localparam int unsigned SH  = 7;
  localparam int unsigned SW  = 8;

  typedef enum logic [1:0] {
    SzNone,
    SzByte,
    SzHalf,
    SzWord
  } access_size_e;

  function automatic logic is_load_type(input int unsigned ty);
    return (ty >= LB) && (ty <= LHU);
  endfunction

  function automatic logic is_store_type(input int unsigned ty);
    return (ty >= SB) && (ty <= SW);
  endfunction

  function automatic access_size_e access_size(input int unsigned ty);
    access_size_e sz;
    case (ty)
      LB, LBU, SB: sz = SzByte;
      LH, LHU, SH: sz = SzHalf;
      LW, SW:      sz = SzWord;
      default:     sz = SzNone;
    endcase
    return sz;
  endfunction

  function automatic logic misaligned(input access_size_e sz, input logic [1:0] ea_lo);
    logic mis;
    case (sz)
      SzHalf:  mis = ea_lo[0];
      SzWord:  mis = |ea_lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsq_addr_fifo.sv
// Generic Depth-entry synchronous FIFO with async active-low reset and synchronous clear.
// Push when full and pop when empty are ignored; clear wins over push and pop.
module lsq_addr_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o && !clear_i;
  assign do_pop  = pop_i && !empty_o && !clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];

  push_not_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !clear_i && full_o));
  pop_not_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop_i && !clear_i && empty_o));

endmodule

// File: rtl/lsq_address_pipe.sv
// Address-generation stage: adds immediate to base, checks alignment, buffers entries and
// steers the head to the load buffer (loads) or the ROB (store addresses) in program order.
module lsq_address_pipe
  import lsq_address_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_W,
  parameter int unsigned ROB_W  = ROB_TAG_W,
  parameter int unsigned TYPE_W = TYPE_CODE_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              lsq_en_in,
  output logic              lsq_ready_out,
  input  logic [XLEN-1:0]   lsq_A_in,
  input  logic [XLEN-1:0]   lsq_vj_in,
  input  logic [ROB_W-1:0]  lsq_dest_in,
  input  logic [TYPE_W-1:0] lsq_type_in,
  output logic              lbuf_en_out,
  input  logic              lbuf_ready_in,
  output logic [XLEN-1:0]   lbuf_A_out,
  output logic [ROB_W-1:0]  lbuf_dest_out,
  output logic [TYPE_W-1:0] lbuf_type_out,
  output logic              lbuf_misalign_out,
  output logic              rob_en_out,
  output logic [ROB_W-1:0]  rob_dest_out,
  output logic [XLEN-1:0]   rob_address_out,
  output logic              rob_misalign_out
);

  localparam int unsigned EntryW = XLEN + ROB_W + TYPE_W + 2;

  logic [XLEN-1:0]   in_ea;
  int unsigned       in_ty;
  logic              in_ld, in_st, in_mis;
  logic              in_fire, fifo_push, fifo_pop, fifo_clear;
  logic              fifo_full, fifo_empty;
  logic [EntryW-1:0] fifo_wdata, fifo_rdata;

  logic [XLEN-1:0]   head_ea;
  logic [ROB_W-1:0]  head_dest;
  logic [TYPE_W-1:0] head_type;
  logic              head_ld, head_mis;

  // Carry out of the EA add is discarded.
  assign in_ea  = lsq_A_in + lsq_vj_in;
  assign in_ty  = 32'(lsq_type_in);
  assign in_ld  = is_load_type(in_ty);
  assign in_st  = is_store_type(in_ty);
  assign in_mis = misaligned(access_size(in_ty), in_ea[1:0]);

  // Reset also forces ready low so nothing is taken while the pipe is held in reset.
  assign lsq_ready_out = rst_in && rdy_in && !fifo_full;

  // Non-memory types complete the handshake but are not stored.
  assign in_fire    = rdy_in && !clear_in && lsq_en_in && lsq_ready_out;
  assign fifo_push  = in_fire && (in_ld || in_st);
  assign fifo_clear = rdy_in && clear_in;
  assign fifo_pop   = rdy_in && !clear_in && !fifo_empty && (!head_ld || lbuf_ready_in);
  assign fifo_wdata = {in_ea, lsq_dest_in, lsq_type_in, in_ld, in_mis};

  assign {head_ea, head_dest, head_type, head_ld, head_mis} = fifo_rdata;

  lsq_addr_fifo #(
    .Width (EntryW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk_in),
    .rst_ni  (rst_in),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .clear_i (fifo_clear),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    lbuf_en_out       = 1'b0;
    lbuf_A_out        = '0;
    lbuf_dest_out     = '0;
    lbuf_type_out     = '0;
    lbuf_misalign_out = 1'b0;
    rob_en_out        = 1'b0;
    rob_dest_out      = '0;
    rob_address_out   = '0;
    rob_misalign_out  = 1'b0;
    if (!fifo_empty) begin
      if (head_ld) begin
        lbuf_en_out       = 1'b1;
        lbuf_A_out        = head_ea;
        lbuf_dest_out     = head_dest;
        lbuf_type_out     = head_type;
        lbuf_misalign_out = head_mis;
      end else begin
        rob_en_out       = 1'b1;
        rob_dest_out     = head_dest;
        rob_address_out  = head_ea;
        rob_misalign_out = head_mis;
      end
    end
  end

endmodule

// File: tb/tb_lsq_address_pipe.sv
// Directed bench for lsq_address_pipe with a queue-based reference model checked every cycle.
module tb_lsq_address_pipe;
  import lsq_address_pipe_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        clear_in = 1'b0;
  logic        lsq_en_in = 1'b0;
  logic        lsq_ready_out;
  logic [31:0] lsq_A_in = '0;
  logic [31:0] lsq_vj_in = '0;
  logic [3:0]  lsq_dest_in = '0;
  logic [5:0]  lsq_type_in = '0;
  logic        lbuf_en_out;
  logic        lbuf_ready_in = 1'b0;
  logic [31:0] lbuf_A_out;
  logic [3:0]  lbuf_dest_out;
  logic [5:0]  lbuf_type_out;
  logic        lbuf_misalign_out;
  logic        rob_en_out;
  logic [3:0]  rob_dest_out;
  logic [31:0] rob_address_out;
  logic        rob_misalign_out;

  lsq_address_pipe #(
    .XLEN   (32),
    .ROB_W  (4),
    .TYPE_W (6),
    .DEPTH  (DEPTH)
  ) dut (
    .clk_in            (clk),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .clear_in          (clear_in),
    .lsq_en_in         (lsq_en_in),
    .lsq_ready_out     (lsq_ready_out),
    .lsq_A_in          (lsq_A_in),
    .lsq_vj_in         (lsq_vj_in),
    .lsq_dest_in       (lsq_dest_in),
    .lsq_type_in       (lsq_type_in),
    .lbuf_en_out       (lbuf_en_out),
    .lbuf_ready_in     (lbuf_ready_in),
    .lbuf_A_out        (lbuf_A_out),
    .lbuf_dest_out     (lbuf_dest_out),
    .lbuf_type_out     (lbuf_type_out),
    .lbuf_misalign_out (lbuf_misalign_out),
    .rob_en_out        (rob_en_out),
    .rob_dest_out      (rob_dest_out),
    .rob_address_out   (rob_address_out),
    .rob_misalign_out  (rob_misalign_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ea;
    logic [3:0]  dest;
    logic [5:0]  ty;
    bit          ld;
    bit          mis;
  } ent_t;

  ent_t mq[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  function automatic bit storable(input logic [5:0] ty);
    int t;
    t = int'(ty);
    return (t >= 1 && t <= 8);
  endfunction

  function automatic ent_t make_ent(input logic [31:0] a, input logic [31:0] vj,
                                    input logic [3:0] d, input logic [5:0] ty);
    ent_t e;
    longint sum;
    sum = longint'(a) + longint'(vj);
    e.ea   = sum[31:0];
    e.dest = d;
    e.ty   = ty;
    e.ld   = (int'(ty) <= 5);
    if (ty == 6'(LH) || ty == 6'(LHU) || ty == 6'(SH)) e.mis = (e.ea % 2) != 0;
    else if (ty == 6'(LW) || ty == 6'(SW))             e.mis = (e.ea % 4) != 0;
    else                                               e.mis = 1'b0;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain program-order queue.
  always @(negedge rst_in) mq.delete();

  always @(posedge clk) begin
    bit acc, pop;
    if (rst_in && rdy_in) begin
      if (clear_in) begin
        mq.delete();
      end else begin
        acc = lsq_en_in && (mq.size() < DEPTH);
        pop = (mq.size() > 0) && (!mq[0].ld || lbuf_ready_in);
        if (pop) void'(mq.pop_front());
        if (acc && storable(lsq_type_in))
          mq.push_back(make_ent(lsq_A_in, lsq_vj_in, lsq_dest_in, lsq_type_in));
      end
    end
  end

  always @(negedge clk) begin
    bit exp_rdy;
    if (chk_en) begin
      exp_rdy = rst_in && rdy_in && (mq.size() < DEPTH);
      check("cmp_ready", 64'(lsq_ready_out), 64'(exp_rdy));
      if (!rst_in || mq.size() == 0) begin
        check("cmp_idle_ctl", 64'({lbuf_en_out, rob_en_out, lbuf_misalign_out, rob_misalign_out,
                                   lbuf_dest_out, rob_dest_out, lbuf_type_out}), 64'(0));
        check("cmp_idle_addr", {lbuf_A_out, rob_address_out}, 64'(0));
      end else if (mq[0].ld) begin
        check("cmp_ld_en", 64'({lbuf_en_out, rob_en_out}), 64'(2'b10));
        check("cmp_ld_addr", 64'(lbuf_A_out), 64'(mq[0].ea));
        check("cmp_ld_fields", 64'({lbuf_dest_out, lbuf_type_out, lbuf_misalign_out}),
              64'({mq[0].dest, mq[0].ty, mq[0].mis}));
      end else begin
        check("cmp_st_en", 64'({lbuf_en_out, rob_en_out}), 64'(2'b01));
        check("cmp_st_addr", 64'(rob_address_out), 64'(mq[0].ea));
        check("cmp_st_fields", 64'({rob_dest_out, rob_misalign_out}),
              64'({mq[0].dest, mq[0].mis}));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int unsigned ty, input logic [31:0] a, input logic [31:0] vj,
                       input logic [3:0] d);
    lsq_en_in   = 1'b1;
    lsq_type_in = 6'(ty);
    lsq_A_in    = a;
    lsq_vj_in   = vj;
    lsq_dest_in = d;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t_ty [12];
    logic [31:0] t_a [12];
    logic [31:0] t_vj [12];
    bit acc;
    int guard;

    t_ty = '{LW, SB, LH, SH, 0, LHU, SW, LBU, 9, LW, SH, LB};
    t_a  = '{32'hC, 32'h3, 32'h3, 32'h2, 32'h0, 32'h1, 32'h0, 32'h7, 32'h0, 32'h1, 32'h5,
             32'h1};
    t_vj = '{32'hFFFF_FFF8, 32'h10, 32'h10, 32'h20, 32'h0, 32'h0, 32'h102, 32'h0, 32'h0,
             32'h1, 32'h100, 32'h2};

    #2 rst_in = 1'b0;
    chk_en = 1'b1;
    step();
    step();
    check("reset_ready", 64'(lsq_ready_out), 64'(0));
    check("reset_lbuf_en", 64'(lbuf_en_out), 64'(0));
    check("reset_rob_en", 64'(rob_en_out), 64'(0));
    rst_in = 1'b1;
    #1 check("ready_after_reset", 64'(lsq_ready_out), 64'(1));

    // Single load, popped the edge after it becomes visible.
    lbuf_ready_in = 1'b1;
    drive(LW, 32'h10, 32'h100, 4'd3);
    step();
    lsq_en_in = 1'b0;
    check("lw_en", 64'(lbuf_en_out), 64'(1));
    check("lw_addr", 64'(lbuf_A_out), 64'h110);
    check("lw_dest", 64'(lbuf_dest_out), 64'(3));
    check("lw_mis", 64'(lbuf_misalign_out), 64'(0));
    check("lw_rob_en", 64'(rob_en_out), 64'(0));
    step();
    check("lw_popped", 64'(lbuf_en_out), 64'(0));

    drive(SH, 32'h1, 32'h200, 4'd5);
    step();
    lsq_en_in = 1'b0;
    check("sh_rob_en", 64'(rob_en_out), 64'(1));
    check("sh_addr", 64'(rob_address_out), 64'h201);
    check("sh_mis", 64'(rob_misalign_out), 64'(1));
    check("sh_dest", 64'(rob_dest_out), 64'(5));
    step();
    check("sh_popped", 64'(rob_en_out), 64'(0));

    drive(SW, 32'h6, 32'h1000, 4'd2);
    step();
    lsq_en_in = 1'b0;
    check("sw_addr", 64'(rob_address_out), 64'h1006);
    check("sw_mis", 64'(rob_misalign_out), 64'(1));
    step();

    // Fill under backpressure, hold a fifth, then drain in order.
    lbuf_ready_in = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(LB, 32'(i), 32'h40, 4'(i));
      step();
    end
    check("full_ready", 64'(lsq_ready_out), 64'(0));
    check("full_head", 64'(lbuf_dest_out), 64'(1));
    drive(LB, 32'h9, 32'h40, 4'd9);
    step();
    step();
    check("held_ready", 64'(lsq_ready_out), 64'(0));
    check("held_head", 64'(lbuf_dest_out), 64'(1));
    lbuf_ready_in = 1'b1;
    step();
    check("drain_head2", 64'(lbuf_dest_out), 64'(2));
    check("drain_ready", 64'(lsq_ready_out), 64'(1));
    step();
    lsq_en_in = 1'b0;
    check("drain_head3", 64'(lbuf_dest_out), 64'(3));
    step();
    check("drain_head4", 64'(lbuf_dest_out), 64'(4));
    step();
    check("drain_head9", 64'(lbuf_dest_out), 64'(9));
    check("drain_addr9", 64'(lbuf_A_out), 64'h49);
    step();
    check("drain_empty", 64'(lbuf_en_out), 64'(0));

    drive(LW, 32'h8, 32'hFFFF_FFFC, 4'd7);
    step();
    lsq_en_in = 1'b0;
    check("wrap_addr", 64'(lbuf_A_out), 64'h4);
    check("wrap_mis", 64'(lbuf_misalign_out), 64'(0));
    step();

    // Mixed traffic with intermittent load backpressure; model checks every cycle.
    for (int i = 0; i < 12; i++) begin
      lbuf_ready_in = (i % 3) != 0;
      drive(t_ty[i], t_a[i], t_vj[i], 4'(i));
      guard = 0;
      do begin
        #1 acc = lsq_ready_out;
        @(posedge clk);
        #1;
        guard++;
        if (guard == 6) lbuf_ready_in = 1'b1;
      end while (!acc && guard < 20);
      if (!acc) check("mix_push_timeout", 64'(0), 64'(1));
    end
    lsq_en_in = 1'b0;
    lbuf_ready_in = 1'b1;
    guard = 0;
    while ((lbuf_en_out || rob_en_out) && guard < 20) begin
      step();
      guard++;
    end
    check("mix_drained", 64'({lbuf_en_out, rob_en_out}), 64'(0));

    // Flush with three entries and a concurrent push.
    lbuf_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(LW, 32'(4 * i), 32'h0, 4'(10 + i));
      step();
    end
    check("clr_pre_head", 64'(lbuf_dest_out), 64'(10));
    drive(LB, 32'h0, 32'h0, 4'd6);
    clear_in = 1'b1;
    step();
    clear_in = 1'b0;
    lsq_en_in = 1'b0;
    check("clr_lbuf_en", 64'(lbuf_en_out), 64'(0));
    check("clr_rob_en", 64'(rob_en_out), 64'(0));
    check("clr_ready", 64'(lsq_ready_out), 64'(1));
    step();
    check("clr_still_empty", 64'(lbuf_en_out), 64'(0));

    // Global stall freezes the pipe.
    drive(LW, 32'h20, 32'h0, 4'd4);
    step();
    lsq_en_in = 1'b0;
    rdy_in = 1'b0;
    lbuf_ready_in = 1'b1;
    drive(SW, 32'h0, 32'h300, 4'd8);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_en", 64'(lbuf_en_out), 64'(1));
      check("hold_dest", 64'(lbuf_dest_out), 64'(4));
      check("hold_ready", 64'(lsq_ready_out), 64'(0));
    end
    rdy_in = 1'b1;
    lsq_en_in = 1'b0;
    step();
    check("hold_popped", 64'({lbuf_en_out, rob_en_out}), 64'(0));

    // Asynchronous reset with traffic in flight.
    lbuf_ready_in = 1'b0;
    drive(LW, 32'h0, 32'h500, 4'd1);
    step();
    drive(SB, 32'h1, 32'h500, 4'd2);
    step();
    lsq_en_in = 1'b0;
    check("mid_pre_en", 64'(lbuf_en_out), 64'(1));
    #2 rst_in = 1'b0;
    #1;
    check("mid_rst_en", 64'({lbuf_en_out, rob_en_out}), 64'(0));
    check("mid_rst_addr", 64'(lbuf_A_out), 64'(0));
    check("mid_rst_ready", 64'(lsq_ready_out), 64'(0));
    step();
    step();
    rst_in = 1'b1;
    #1;
    check("post_rst_empty", 64'({lbuf_en_out, rob_en_out}), 64'(0));
    check("post_rst_ready", 64'(lsq_ready_out), 64'(1));
    step();
    step();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
